// File: rtl/vga_mode_pkg.sv
// Shared types and the constant VGA mode table for the mode sequencer.
// Quarter-frame lines are derived from v_start/v_end by make_mode().
package vga_mode_pkg;

    typedef logic [1:0]  mode_idx_t;
    typedef logic [11:0] line_t;

    typedef struct packed {
        line_t h_total;
        line_t h_sync;
        line_t h_start;
        line_t h_end;
        line_t v_total;
        line_t v_sync;
        line_t v_start;
        line_t v_end;
        line_t v_active_14;
        line_t v_active_24;
        line_t v_active_34;
    } vga_timing_t;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_WAIT_EOF,
        ST_HOLD
    } state_t;

    typedef vga_timing_t [3:0] mode_table_t;

    function automatic vga_timing_t make_mode(
        input line_t ht, input line_t hs, input line_t hst, input line_t he,
        input line_t vt, input line_t vs, input line_t vst, input line_t ve
    );
        vga_timing_t t;
        line_t       act;
        act           = ve - vst;
        t.h_total     = ht;
        t.h_sync      = hs;
        t.h_start     = hst;
        t.h_end       = he;
        t.v_total     = vt;
        t.v_sync      = vs;
        t.v_start     = vst;
        t.v_end       = ve;
        t.v_active_14 = vst + (act >> 2);
        t.v_active_24 = vst + (act >> 1);
        t.v_active_34 = vst + (act >> 1) + (act >> 2);
        return t;
    endfunction

    function automatic mode_table_t build_table();
        mode_table_t tbl;
        tbl[0] = make_mode(12'd799,  12'd95,  12'd141, 12'd781,  12'd524,  12'd1, 12'd34, 12'd514);
        tbl[1] = make_mode(12'd1055, 12'd127, 12'd215, 12'd1015, 12'd627,  12'd3, 12'd26, 12'd626);
        tbl[2] = make_mode(12'd1343, 12'd135, 12'd293, 12'd1317, 12'd805,  12'd5, 12'd34, 12'd802);
        tbl[3] = make_mode(12'd1687, 12'd111, 12'd357, 12'd1637, 12'd1065, 12'd2, 12'd40, 12'd1064);
        return tbl;
    endfunction

    localparam mode_table_t MODE_TABLE = build_table();

endpackage

// File: rtl/vga_mode_rom.sv
// Combinational mode-table lookup: mode index to full timing record.
module vga_mode_rom
    import vga_mode_pkg::*;
(
    input  mode_idx_t   sel,
    output vga_timing_t timing
);

    assign timing = MODE_TABLE[sel];

endmodule

// File: rtl/vga_mode_sequencer.sv
// Drives the VGA generator timing bus and applies mode changes at frame end,
// holding the generator in reset while new timing settles.
// Optional frame_end watchdog: define MODE_SWITCH_TIMEOUT_EN.
module vga_mode_sequencer
    import vga_mode_pkg::*;
#(
    parameter int DEFAULT_MODE   = 0,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_req_valid,
    input  logic [1:0]  mode_req_sel,
    output logic        mode_req_ready,
    input  logic        frame_end,
    output logic        gen_reset_n,
    output logic [11:0] h_total,
    output logic [11:0] h_sync,
    output logic [11:0] h_start,
    output logic [11:0] h_end,
    output logic [11:0] v_total,
    output logic [11:0] v_sync,
    output logic [11:0] v_start,
    output logic [11:0] v_end,
    output logic [11:0] v_active_14,
    output logic [11:0] v_active_24,
    output logic [11:0] v_active_34,
    output logic [1:0]  mode_cur,
    output logic        mode_done,
    output logic        mode_timeout
);

    localparam int                HOLD_W    = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam mode_idx_t         BOOT_MODE = mode_idx_t'(DEFAULT_MODE);

    if (HOLD_CYCLES < 2 || DEFAULT_MODE < 0 || DEFAULT_MODE > 3 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << 23)) begin : g_bad_params
        $error("vga_mode_sequencer: parameter out of range");
    end

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    mode_idx_t         pend_sel_q, pend_sel_d;
    mode_idx_t         mode_cur_q, mode_cur_d;
    vga_timing_t       timing_q, timing_d;
    vga_timing_t       rom_timing;
    logic              gen_rst_n_q, gen_rst_n_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              accept;
    logic              hold_last;
    logic              switch_now;

    assign accept    = mode_req_valid && ready_q;
    assign hold_last = (hold_cnt_q == HOLD_LAST);

    vga_mode_rom u_rom (
        .sel    (pend_sel_q),
        .timing (rom_timing)
    );

`ifdef MODE_SWITCH_TIMEOUT_EN
    localparam logic [22:0] TO_LAST = 23'(TIMEOUT_CYCLES - 1);

    logic [22:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;
    logic        to_expired;

    assign to_expired = (to_cnt_q == TO_LAST);
    assign switch_now = frame_end || to_expired;

    // Counter is zero outside WAIT_EOF, so it restarts on every entry.
    always_comb begin
        to_cnt_d  = '0;
        timeout_d = 1'b0;
        if (state_q == ST_WAIT_EOF) begin
            to_cnt_d  = to_cnt_q + 1'b1;
            timeout_d = to_expired && !frame_end;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mode_timeout = timeout_q;
`else
    assign switch_now   = frame_end;
    assign mode_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_BOOT;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:     if (hold_last) state_d = ST_RUN;
            ST_RUN:      if (accept && mode_req_sel != mode_cur_q) state_d = ST_WAIT_EOF;
            ST_WAIT_EOF: if (switch_now) state_d = ST_HOLD;
            ST_HOLD:     if (hold_last) state_d = ST_RUN;
            default:     state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        hold_cnt_d  = '0;
        pend_sel_d  = pend_sel_q;
        mode_cur_d  = mode_cur_q;
        timing_d    = timing_q;
        gen_rst_n_d = gen_rst_n_q;
        done_d      = 1'b0;
        ready_d     = (state_d == ST_RUN);
        case (state_q)
            ST_BOOT, ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_last) begin
                    hold_cnt_d  = '0;
                    gen_rst_n_d = 1'b1;
                    done_d      = (state_q == ST_HOLD);
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (mode_req_sel == mode_cur_q) done_d     = 1'b1;
                    else                            pend_sel_d = mode_req_sel;
                end
            end
            ST_WAIT_EOF: begin
                // Timing bus only moves on the edge that drops gen_reset_n.
                if (switch_now) begin
                    timing_d    = rom_timing;
                    mode_cur_d  = pend_sel_q;
                    gen_rst_n_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q  <= '0;
            pend_sel_q  <= BOOT_MODE;
            mode_cur_q  <= BOOT_MODE;
            timing_q    <= MODE_TABLE[BOOT_MODE];
            gen_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            pend_sel_q  <= pend_sel_d;
            mode_cur_q  <= mode_cur_d;
            timing_q    <= timing_d;
            gen_rst_n_q <= gen_rst_n_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign mode_req_ready = ready_q;
    assign gen_reset_n    = gen_rst_n_q;
    assign mode_cur       = mode_cur_q;
    assign mode_done      = done_q;
    assign h_total        = timing_q.h_total;
    assign h_sync         = timing_q.h_sync;
    assign h_start        = timing_q.h_start;
    assign h_end          = timing_q.h_end;
    assign v_total        = timing_q.v_total;
    assign v_sync         = timing_q.v_sync;
    assign v_start        = timing_q.v_start;
    assign v_end          = timing_q.v_end;
    assign v_active_14    = timing_q.v_active_14;
    assign v_active_24    = timing_q.v_active_24;
    assign v_active_34    = timing_q.v_active_34;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Scoreboard bench for vga_mode_sequencer: expected generator-reset edges and
// done/timeout pulses are queued by the stimulus and matched by a monitor.
`timescale 1ns/1ps
module tb_vga_mode_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode_req_valid;
    logic [1:0]  mode_req_sel;
    logic        mode_req_ready;
    logic        frame_end;
    logic        gen_reset_n;
    logic [11:0] h_total, h_sync, h_start, h_end;
    logic [11:0] v_total, v_sync, v_start, v_end;
    logic [11:0] v_active_14, v_active_24, v_active_34;
    logic [1:0]  mode_cur;
    logic        mode_done;
    logic        mode_timeout;

    vga_mode_sequencer #(
        .DEFAULT_MODE   (0),
        .HOLD_CYCLES    (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mode_req_valid (mode_req_valid),
        .mode_req_sel   (mode_req_sel),
        .mode_req_ready (mode_req_ready),
        .frame_end      (frame_end),
        .gen_reset_n    (gen_reset_n),
        .h_total        (h_total),
        .h_sync         (h_sync),
        .h_start        (h_start),
        .h_end          (h_end),
        .v_total        (v_total),
        .v_sync         (v_sync),
        .v_start        (v_start),
        .v_end          (v_end),
        .v_active_14    (v_active_14),
        .v_active_24    (v_active_24),
        .v_active_34    (v_active_34),
        .mode_cur       (mode_cur),
        .mode_done      (mode_done),
        .mode_timeout   (mode_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [3:0] EV_RISE = 4'd1;
    localparam logic [3:0] EV_FALL = 4'd2;
    localparam logic [3:0] EV_DONE = 4'd3;
    localparam logic [3:0] EV_TMO  = 4'd4;

    int n_checks = 0;
    int n_errors = 0;
    logic [153:0] exp_q[$];
    logic         prev_gen = 1'b0;

    logic [131:0] bus_obs;
    assign bus_obs = {h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end,
                      v_active_14, v_active_24, v_active_34};

    // Hand-computed timing records (quarter lines worked out from v_start/v_end).
    function automatic logic [131:0] bus_of(input int m);
        case (m)
            0:       return {12'd799,  12'd95,  12'd141, 12'd781,  12'd524,  12'd1, 12'd34, 12'd514,
                             12'd154, 12'd274, 12'd394};
            1:       return {12'd1055, 12'd127, 12'd215, 12'd1015, 12'd627,  12'd3, 12'd26, 12'd626,
                             12'd176, 12'd326, 12'd476};
            2:       return {12'd1343, 12'd135, 12'd293, 12'd1317, 12'd805,  12'd5, 12'd34, 12'd802,
                             12'd226, 12'd418, 12'd610};
            default: return {12'd1687, 12'd111, 12'd357, 12'd1637, 12'd1065, 12'd2, 12'd40, 12'd1064,
                             12'd296, 12'd552, 12'd808};
        endcase
    endfunction

    function automatic logic [153:0] mk_ev(input logic [3:0] k, input int c, input int m);
        return {k, 16'(c), 2'(m), bus_of(m)};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic observe(input logic [3:0] k);
        logic [153:0] got;
        got = {k, 16'(cyc), mode_cur, bus_obs};
        if (exp_q.size() == 0) check("unexpected_event", 160'(got), 160'(0));
        else                   check("event", 160'(got), 160'(exp_q.pop_front()));
    endtask

    // Monitor: every generator-reset edge and every done/timeout pulse is an event.
    always @(negedge clk) begin
        if (gen_reset_n === 1'b1 && prev_gen === 1'b0) observe(EV_RISE);
        if (gen_reset_n === 1'b0 && prev_gen === 1'b1) observe(EV_FALL);
        if (mode_done === 1'b1)                        observe(EV_DONE);
        if (mode_timeout === 1'b1)                     observe(EV_TMO);
        prev_gen <= gen_reset_n;
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        int r, a, c, d;
        reset          = 1'b1;
        mode_req_valid = 1'b0;
        mode_req_sel   = 2'd0;
        frame_end      = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_gen_reset_n", 160'(gen_reset_n), 160'(0));
        check("rst_ready",       160'(mode_req_ready), 160'(0));
        check("rst_done",        160'(mode_done), 160'(0));
        check("rst_timeout",     160'(mode_timeout), 160'(0));
        check("rst_mode_cur",    160'(mode_cur), 160'(0));
        check("rst_bus",         160'(bus_obs), 160'(bus_of(0)));
        check("rst_v_active_14", 160'(v_active_14), 160'(154));

        // Boot: generator released 16 cycles after reset, no done pulse.
        r = cyc;
        exp_q.push_back(mk_ev(EV_RISE, r + 16, 0));
        reset = 1'b0;
        wait_until(r + 8);
        check("boot_gen_low", 160'(gen_reset_n), 160'(0));
        check("boot_ready",   160'(mode_req_ready), 160'(0));
        wait_until(r + 16);
        check("run_ready", 160'(mode_req_ready), 160'(1));

        // Switch to mode 2 on a frame_end 100 cycles after accept.
        a = cyc + 1;
        mode_req_valid = 1'b1;
        mode_req_sel   = 2'd2;
        @(negedge clk);
        mode_req_valid = 1'b0;
        check("wait_ready", 160'(mode_req_ready), 160'(0));
        wait_until(a + 50);
        mode_req_valid = 1'b1;
        mode_req_sel   = 2'd1;
        check("wait_req_blocked", 160'(mode_req_ready), 160'(0));
        wait_until(a + 99);
        frame_end = 1'b1;
        exp_q.push_back(mk_ev(EV_FALL, a + 100, 2));
        exp_q.push_back(mk_ev(EV_RISE, a + 116, 2));
        exp_q.push_back(mk_ev(EV_DONE, a + 116, 2));
        @(negedge clk);
        frame_end = 1'b0;
        wait_until(a + 105);
        check("hold_req_blocked", 160'(mode_req_ready), 160'(0));
        check("hold_gen_low",     160'(gen_reset_n), 160'(0));

        // Held request accepted in first RUN cycle; frame_end in that cycle ignored.
        wait_until(a + 116);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end      = 1'b0;
        mode_req_valid = 1'b0;
        check("accept_ready_drop", 160'(mode_req_ready), 160'(0));
        check("accept_mode_kept",  160'(mode_cur), 160'(2));
        wait_until(a + 125);
        check("ignored_eof_gen", 160'(gen_reset_n), 160'(1));
        check("ignored_eof_bus", 160'(bus_obs), 160'(bus_of(2)));
        wait_until(a + 129);
        frame_end = 1'b1;
        exp_q.push_back(mk_ev(EV_FALL, a + 130, 1));
        exp_q.push_back(mk_ev(EV_RISE, a + 146, 1));
        exp_q.push_back(mk_ev(EV_DONE, a + 146, 1));
        @(negedge clk);
        frame_end = 1'b0;

        // Same-mode request: done next cycle, generator undisturbed.
        wait_until(a + 146);
        mode_req_valid = 1'b1;
        mode_req_sel   = 2'd1;
        exp_q.push_back(mk_ev(EV_DONE, a + 147, 1));
        @(negedge clk);
        mode_req_valid = 1'b0;
        @(negedge clk);
        check("same_ready", 160'(mode_req_ready), 160'(1));
        check("same_gen",   160'(gen_reset_n), 160'(1));

        // Reset during HOLD of a switch to mode 3.
        c = a + 150;
        wait_until(c);
        mode_req_valid = 1'b1;
        mode_req_sel   = 2'd3;
        @(negedge clk);
        mode_req_valid = 1'b0;
        wait_until(c + 10);
        frame_end = 1'b1;
        exp_q.push_back(mk_ev(EV_FALL, c + 11, 3));
        @(negedge clk);
        frame_end = 1'b0;
        wait_until(c + 15);
        check("hold3_mode_cur", 160'(mode_cur), 160'(3));
        reset = 1'b1;
        exp_q.push_back(mk_ev(EV_RISE, c + 33, 0));
        wait_until(c + 17);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_mode_cur", 160'(mode_cur), 160'(0));
        check("midrst_bus",      160'(bus_obs), 160'(bus_of(0)));
        check("midrst_ready",    160'(mode_req_ready), 160'(0));
        wait_until(c + 34);
        check("midrst_run_ready", 160'(mode_req_ready), 160'(1));
        wait_until(c + 40);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;

        // Request with no frame_end: watchdog forces the switch if enabled.
        d = c + 50;
        wait_until(d);
        mode_req_valid = 1'b1;
        mode_req_sel   = 2'd1;
        @(negedge clk);
        mode_req_valid = 1'b0;
`ifdef MODE_SWITCH_TIMEOUT_EN
        exp_q.push_back(mk_ev(EV_FALL, d + 65, 1));
        exp_q.push_back(mk_ev(EV_TMO,  d + 65, 1));
        exp_q.push_back(mk_ev(EV_RISE, d + 81, 1));
        exp_q.push_back(mk_ev(EV_DONE, d + 81, 1));
        wait_until(d + 60);
        check("tmo_still_waiting", 160'(gen_reset_n), 160'(1));
        wait_until(d + 100);
`else
        wait_until(d + 200);
        check("no_tmo_gen",      160'(gen_reset_n), 160'(1));
        check("no_tmo_mode_cur", 160'(mode_cur), 160'(0));
        frame_end = 1'b1;
        exp_q.push_back(mk_ev(EV_FALL, d + 201, 1));
        exp_q.push_back(mk_ev(EV_RISE, d + 217, 1));
        exp_q.push_back(mk_ev(EV_DONE, d + 217, 1));
        @(negedge clk);
        frame_end = 1'b0;
        wait_until(d + 230);
`endif
        check("final_mode_cur", 160'(mode_cur), 160'(1));
        check("queue_drained",  160'(exp_q.size()), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
